// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: registered, flow-controlled front end for the combinational ALU.
// Tagged commands are queued in a small FIFO, issued one at a time onto the ALU
// inputs, and the ALU result/flags are captured one cycle later and returned
// over a valid/ready response port in command order.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready = !fifo_full)
//   cmd_opcode/a/b/shamt/tag        command payload
//   alu_opcode/input1/input2/shiftValue  registered drive to the ALU
//   alu_result, alu_carry/zero/overflow/sign  ALU outputs
//   rsp_valid/rsp_ready             response handshake
//   rsp_result/flags/tag/err        response payload, flags = {carry, zero, overflow, sign}
//   ops_done                        wrapping count of completed responses
module alu_cmd_issuer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [4:0]       cmd_shamt,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      ops_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned PW    = PTR_W + 1;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned SH_W  = 5;
  localparam int unsigned CNT_W = 16;
  localparam logic [OP_W-1:0] OP_DIV = 4'd0;
  localparam logic [OP_W-1:0] OP_MAX = 4'd8;

  typedef struct packed {
    logic [OP_W-1:0]  opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SH_W-1:0]  shamt;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_d;
  cmd_t            mem [DEPTH];
  cmd_t            cmd_in, head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            full, empty, head_err;
  logic            push_c, pop_c, capture_c, rsp_hs_c;
  logic [TAG_W-1:0] tag_q;
  logic            err_q;

  // FIFO status: extra pointer bit distinguishes full from empty
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign cmd_ready = !full;
  assign push_c    = cmd_valid && !full;

  assign cmd_in = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, shamt: cmd_shamt, tag: cmd_tag};
  assign head   = mem[rd_ptr[PTR_W-1:0]];

  // Illegal opcode or divide-by-zero: ALU output is discarded for these
  assign head_err = (head.opcode > OP_MAX) || ((head.opcode == OP_DIV) && (head.b == '0));

  // FIFO storage (no reset needed, validity tracked by pointers)
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[PTR_W-1:0]] <= cmd_in;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d   = state;
    pop_c     = 1'b0;
    capture_c = 1'b0;
    rsp_hs_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop_c   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        capture_c = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_hs_c = 1'b1;
          if (!empty) begin
            pop_c   = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue registers, response capture and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode     <= '0;
      alu_input1     <= '0;
      alu_input2     <= '0;
      alu_shiftValue <= '0;
      tag_q          <= '0;
      err_q          <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_result     <= '0;
      rsp_flags      <= '0;
      rsp_tag        <= '0;
      rsp_err        <= 1'b0;
      ops_done       <= '0;
    end else begin
      if (pop_c) begin
        alu_opcode     <= head.opcode;
        alu_input1     <= head.a;
        alu_input2     <= head.b;
        alu_shiftValue <= head.shamt;
        tag_q          <= head.tag;
        err_q          <= head_err;
      end
      if (capture_c) begin
        rsp_valid  <= 1'b1;
        rsp_result <= err_q ? '0 : alu_result;
        rsp_flags  <= err_q ? 4'b0000 : {alu_carry, alu_zero, alu_overflow, alu_sign};
        rsp_tag    <= tag_q;
        rsp_err    <= err_q;
      end else if (rsp_hs_c) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_hs_c) ops_done <= ops_done + CNT_W'(1);
    end
  end

endmodule
